// File: rtl/phase_step_meter.sv
// phase_step_meter
//   Recovers the phase_step setting of a phase-accumulator generator by
//   timing the gaps between successive phase index changes. The generator
//   holds each value for phase_step+1 clocks, so the gap length minus one is
//   the step. Lock is declared after LOCK_COUNT consecutive equal gaps.
//
// Parameters
//   LOCK_COUNT  consecutive equal intervals needed for lock (1..15)
//   TIMEOUT     clocks without a phase change before measurement is abandoned
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   phase_in    observed 10-bit phase index
//   clear       synchronous restart (prev keeps sampling)
//   step_out    recovered step, held until the next lock
//   step_valid  pulse on every edge confirming the locked step
//   locked      high while locked
//   seq_err     pulse on a non-sequential phase change
//   timeout     pulse when the stream stalls
//   wrap        pulse on a valid 1023->0 edge
module phase_step_meter #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter logic [31:0] TIMEOUT    = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  phase_in,
  input  logic        clear,
  output logic [31:0] step_out,
  output logic        step_valid,
  output logic        locked,
  output logic        seq_err,
  output logic        timeout,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  state_t      state;
  logic [9:0]  prev;
  logic [31:0] run_cnt;
  logic [31:0] candidate;
  logic [3:0]  match_cnt;

  logic is_edge, is_valid, is_wrap;

  // prev + 1 is evaluated in 10 bits, so 1023 -> 0 is a valid advance.
  assign is_edge  = (phase_in != prev);
  assign is_valid = (phase_in == prev + 10'd1);
  assign is_wrap  = is_valid && (prev == 10'h3FF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      run_cnt    <= '0;
      candidate  <= '0;
      match_cnt  <= '0;
      step_out   <= '0;
      step_valid <= 1'b0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      timeout    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      prev       <= phase_in;
      step_valid <= 1'b0;
      seq_err    <= 1'b0;
      timeout    <= 1'b0;
      wrap       <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        run_cnt   <= '0;
        candidate <= '0;
        match_cnt <= '0;
        step_out  <= '0;
        locked    <= 1'b0;
      end else begin
        // At an edge run_cnt holds (cycles since previous edge) - 1.
        if (is_edge)                run_cnt <= '0;
        else if (run_cnt < TIMEOUT) run_cnt <= run_cnt + 32'd1;

        if (is_edge) begin
          if (state == IDLE) begin
            // First edge is only a start marker; its value is not checked.
            state <= MEASURE;
          end else if (!is_valid) begin
            // Bad edge restarts measurement and opens a new interval.
            seq_err <= 1'b1;
            locked  <= 1'b0;
            state   <= MEASURE;
          end else begin
            wrap <= is_wrap;
            case (state)
              MEASURE: begin
                candidate <= run_cnt;
                match_cnt <= 4'd1;
                if (LC == 4'd1) begin
                  state      <= LOCKED;
                  locked     <= 1'b1;
                  step_out   <= run_cnt;
                  step_valid <= 1'b1;
                end else begin
                  state <= TRACK;
                end
              end
              TRACK: begin
                if (run_cnt == candidate) begin
                  match_cnt <= match_cnt + 4'd1;
                  if (match_cnt + 4'd1 >= LC) begin
                    state      <= LOCKED;
                    locked     <= 1'b1;
                    step_out   <= candidate;
                    step_valid <= 1'b1;
                  end
                end else begin
                  candidate <= run_cnt;
                  match_cnt <= 4'd1;
                end
              end
              LOCKED: begin
                if (run_cnt == step_out) begin
                  step_valid <= 1'b1;
                end else begin
                  // step_out deliberately keeps the old value until relock.
                  locked    <= 1'b0;
                  state     <= TRACK;
                  candidate <= run_cnt;
                  match_cnt <= 4'd1;
                end
              end
              default: ;
            endcase
          end
        end else if (state != IDLE && run_cnt == TIMEOUT) begin
          // Dropping to IDLE makes this fire once per stall.
          timeout <= 1'b1;
          locked  <= 1'b0;
          state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_step_meter.sv
// Randomized scoreboard bench for phase_step_meter. The driver computes the
// expected registered outputs from a timestamp-based reference model and
// queues them; the monitor compares them one cycle later.
module tb_phase_step_meter;

  localparam int LC = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  phase_in;
  logic        clear;
  logic [31:0] step_out;
  logic        step_valid, locked, seq_err, timeout, wrap;

  always #5 clk = ~clk;

  phase_step_meter #(.LOCK_COUNT(LC), .TIMEOUT(32'(TO))) dut (
    .clk(clk), .rst(rst), .phase_in(phase_in), .clear(clear),
    .step_out(step_out), .step_valid(step_valid), .locked(locked),
    .seq_err(seq_err), .timeout(timeout), .wrap(wrap)
  );

  typedef struct packed {
    logic [31:0] step;
    logic sv, lk, se, to, wr;
  } exp_t;

  exp_t q[$];
  int checks = 0, passed = 0;

  // Reference model: time-stamped edges, acquisition progress as a count.
  int cyc = 0, last_edge = 0, mprev = 0;
  int acq = 0;          // 0 waiting for marker, 1 marker seen, 2 counting, 3 locked
  int cand = 0, nmatch = 0, mstep = 0;
  bit mlocked = 0;
  int ph_cur = 0;

  task automatic drive(input bit r, input bit c, input int ph);
    exp_t e;
    int gap;
    bit good;
    @(negedge clk);
    rst = r; clear = c; phase_in = 10'(ph);
    cyc++;
    e = '0;
    if (r) begin
      mprev = 0; last_edge = cyc; acq = 0; cand = 0; nmatch = 0;
      mstep = 0; mlocked = 0;
    end else begin
      gap = cyc - last_edge - 1;
      if (gap > TO) gap = TO;
      if (c) begin
        acq = 0; cand = 0; nmatch = 0; mstep = 0; mlocked = 0; last_edge = cyc;
      end else if (ph != mprev) begin
        last_edge = cyc;
        good = (ph == (mprev + 1) % 1024);
        if (acq == 0) acq = 1;
        else if (!good) begin
          e.se = 1; mlocked = 0; acq = 1;
        end else begin
          e.wr = (mprev == 1023);
          if (acq == 1) begin
            cand = gap; nmatch = 1; acq = 2;
          end else if (acq == 2) begin
            if (gap == cand) begin
              nmatch++;
              if (nmatch >= LC) begin
                acq = 3; mlocked = 1; mstep = cand; e.sv = 1;
              end
            end else begin
              cand = gap; nmatch = 1;
            end
          end else begin
            if (gap == mstep) e.sv = 1;
            else begin
              mlocked = 0; acq = 2; cand = gap; nmatch = 1;
            end
          end
        end
      end else if (acq != 0 && gap == TO) begin
        e.to = 1; mlocked = 0; acq = 0;
      end
      mprev = ph;
    end
    e.step = 32'(mstep);
    e.lk   = mlocked;
    q.push_back(e);
  endtask

  task automatic hold(input int step, input int nvals);
    for (int v = 0; v < nvals; v++) begin
      for (int k = 0; k <= step; k++) drive(0, 0, ph_cur);
      ph_cur = (ph_cur + 1) % 1024;
    end
  endtask

  task automatic freeze(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, ph_cur);
  endtask

  // Reset asserted between clock edges must clear outputs with no edge.
  task automatic async_rst_check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({step_out, step_valid, locked, seq_err, timeout, wrap} == '0) passed++;
    else $display("FAIL async_rst: got step=%0d sv=%b lk=%b se=%b to=%b wr=%b, want all 0",
                  step_out, step_valid, locked, seq_err, timeout, wrap);
  endtask

  // Monitor: outputs are registered and present every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (step_out === e.step && step_valid === e.sv && locked === e.lk &&
            seq_err === e.se && timeout === e.to && wrap === e.wr)
          passed++;
        else
          $display("FAIL outputs t=%0t: got step=%0d sv=%b lk=%b se=%b to=%b wr=%b, want step=%0d sv=%b lk=%b se=%b to=%b wr=%b",
                   $time, step_out, step_valid, locked, seq_err, timeout, wrap,
                   e.step, e.sv, e.lk, e.se, e.to, e.wr);
      end
    end
  end

  initial begin
    int r, st;
    rst = 1'b1; clear = 1'b0; phase_in = '0;
    repeat (3) drive(1, 0, 0);

    // step 3 from phase 0
    ph_cur = 0;  hold(3, 12);
    // step 0 across the wrap
    drive(0, 1, ph_cur);
    ph_cur = 1012; hold(0, 24);
    // step 5, then a +2 jump, then relock
    hold(5, 8);
    ph_cur = (ph_cur + 1) % 1024;
    hold(5, 8);
    // step 3 switching to step 7
    hold(3, 8);
    hold(7, 8);
    // stall while locked, then a fresh start
    freeze(150);
    hold(2, 8);
    // asynchronous reset mid-lock, then relock
    async_rst_check();
    drive(1, 0, ph_cur);
    drive(1, 0, ph_cur);
    hold(2, 8);
    // clear mid-lock, then relock
    hold(4, 7);
    drive(0, 1, ph_cur);
    hold(4, 8);

    // randomized segments; step is often repeated so lock is reached
    st = 3;
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 11);
      if (r == 0) ph_cur = $urandom_range(0, 1023);
      else if (r == 1) freeze($urandom_range(95, 110));
      else if (r == 2) drive(0, 1, ph_cur);
      else if (r == 3) repeat ($urandom_range(1, 2)) drive(1, 0, ph_cur);
      else begin
        if (r < 6) st = $urandom_range(0, 8);
        hold(st, $urandom_range(1, 8));
      end
    end
    hold(1, 4);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
